// File: rtl/bb8051_pkg.sv
// Shared constants for the bb8051 fetch front end.
// Holds the reset PC default and the legal instruction length range.
package bb8051_pkg;

  localparam logic [15:0] RST_PC_DEF = 16'h0000;
  localparam logic [1:0]  LEN_MIN    = 2'd1;
  localparam logic [1:0]  LEN_MAX    = 2'd3;

endpackage

// File: rtl/bb8051_prefetch_fifo.sv
// Circular byte store for the prefetch queue: single-byte push,
// multi-byte pop (1..3), flush, and the three head bytes.
// Ports: clk, rst, flush, push, push_data, pop, pop_len,
//        b0/b1/b2 (head bytes, 00 when absent), count.
module bb8051_prefetch_fifo
  import bb8051_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic [1:0]    pop_len,
  output logic [7:0]    b0,
  output logic [7:0]    b1,
  output logic [7:0]    b2,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rd_p1;
  logic [PW-1:0] rd_p2;
  logic [CW-1:0] pop_n;

  assign rd_p1 = rd_ptr + PW'(1);
  assign rd_p2 = rd_ptr + PW'(2);
  assign pop_n = pop ? CW'(pop_len) : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(pop_len);
      end
      cnt <= cnt + CW'(push) - pop_n;
    end
  end

  assign b0    = (cnt > CW'(0)) ? mem[rd_ptr] : 8'h00;
  assign b1    = (cnt > CW'(1)) ? mem[rd_p1]  : 8'h00;
  assign b2    = (cnt > CW'(2)) ? mem[rd_p2]  : 8'h00;
  assign count = cnt;

endmodule

// File: rtl/bb8051_fetch_queue.sv
// 8051 instruction prefetch queue with jump redirect and MOVC port.
// Ports: clk, rst, rom_en/rom_addr/rom_q (sync ROM), jmp_valid/
// jmp_addr, consume/instr_len, op1..3_out, byte_cnt, pc_out,
// movc_req/movc_addr/movc_data/movc_ack.
module bb8051_fetch_queue
  import bb8051_pkg::*;
#(
  parameter  int              ADDR_W = 16,
  parameter  int              DEPTH  = 8,
  parameter  logic [ADDR_W-1:0] RST_PC = ADDR_W'(RST_PC_DEF),
  localparam int              CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              consume,
  input  logic [1:0]        instr_len,
  output logic [7:0]        op1_out,
  output logic [7:0]        op2_out,
  output logic [7:0]        op3_out,
  output logic [CW-1:0]     byte_cnt,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              movc_req,
  input  logic [ADDR_W-1:0] movc_addr,
  output logic [7:0]        movc_data,
  output logic              movc_ack
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_q;
  logic              inflight;
  logic [7:0]        movc_hold;
  logic [CW:0]       occ;
  logic              issue;
  logic              len_ok;
  logic              pop;
  logic              push;

  // Occupancy counts the byte still in flight so the queue never
  // overfills; same-cycle consumption is deliberately ignored.
  assign occ   = {1'b0, byte_cnt} + (CW + 1)'(inflight);
  assign issue = !rst && !movc_req && !jmp_valid
               && (occ < (CW + 1)'(DEPTH));

  assign len_ok = (instr_len >= LEN_MIN)
               && (instr_len <= LEN_MAX)
               && (CW'(instr_len) <= byte_cnt);
  assign pop    = consume && len_ok && !jmp_valid;

  // A jump squashes the byte returning this cycle.
  assign push   = inflight && !jmp_valid;

  assign rom_en   = !rst && (movc_req || issue);
  assign rom_addr = movc_req ? movc_addr : fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RST_PC;
      pc_q      <= RST_PC;
      inflight  <= 1'b0;
      movc_ack  <= 1'b0;
      movc_hold <= 8'h00;
    end else begin
      inflight <= issue;
      movc_ack <= movc_req;
      if (movc_ack) begin
        movc_hold <= rom_q;
      end
      unique case (1'b1)
        jmp_valid: begin
          fetch_pc <= jmp_addr;
          pc_q     <= jmp_addr;
        end
        default: begin
          if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
          end
          if (pop) begin
            pc_q <= pc_q + ADDR_W'(instr_len);
          end
        end
      endcase
    end
  end

  // The ack cycle passes rom_q straight through; the holding
  // register keeps it afterwards.
  assign movc_data = movc_ack ? rom_q : movc_hold;
  assign pc_out    = pc_q;

  bb8051_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (jmp_valid),
    .push      (push),
    .push_data (rom_q),
    .pop       (pop),
    .pop_len   (instr_len),
    .b0        (op1_out),
    .b1        (op2_out),
    .b2        (op3_out),
    .count     (byte_cnt)
  );

endmodule
